rd_active_vertex_multi: RTL

Per-core active-vertex scheduler with a parametrised frontier bitmap. It scans the current-iteration bitmap and emits up to LANES active vertex IDs per cycle to the edge-fetch stage over a valid/ready handshake. It accepts backend updates into the next-iteration bitmap and sequences iteration boundaries with the backend. It replaces the fixed 32-bit, single-lane scheduler at the front of each core pipeline.

---
 rtl/rd_av_pkg.sv | 11 +
 rtl/rd_active_vertex_multi_extract.sv | 27 ++
 rtl/rd_active_vertex_multi.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rd_av_pkg.sv
// rd_av_pkg: shared FSM state, ID composition and width helpers for the active-vertex scheduler.
package rd_av_pkg;
  typedef enum logic [2:0] {INIT, FETCH, SCAN, END, DONE} state_t;
  function automatic int split_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] compose_id(input logic [31:0] word, input logic [31:0] bit_idx,
                                             input int bl, input int cnw, input int core_id);
    return ((word * 32'(bl) + bit_idx) << cnw) | 32'(core_id);
  endfunction
endpackage

// File: rtl/rd_active_vertex_multi_extract.sv
// multi_lane_bit_extract: lowest LANES set bits of a word, ascending, plus the word with them cleared.
module multi_lane_bit_extract
  import rd_av_pkg::*;
#(
  parameter int BITMAP_LENGTH = 64,
  parameter int LANES = 2,
  localparam int BIT_W = split_w(BITMAP_LENGTH)
) (
  input  logic [BITMAP_LENGTH-1:0] word,
  output logic [LANES*BIT_W-1:0]   lane_idx,
  output logic [LANES-1:0]         lane_valid,
  output logic [BITMAP_LENGTH-1:0] cleared
);
  logic [BITMAP_LENGTH-1:0] rem;
  always_comb begin
    rem = word;
    lane_idx = '0;
    lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_valid[l] = |rem;
      for (int i = BITMAP_LENGTH - 1; i >= 0; i--)
        if (rem[i]) lane_idx[l*BIT_W +: BIT_W] = BIT_W'(i);
      rem = rem & (rem - BITMAP_LENGTH'(1));
    end
    cleared = rem;
  end
endmodule

// File: rtl/rd_active_vertex_multi.sv
// rd_active_vertex_multi: double-banked frontier bitmap scheduler emitting up to LANES vertex IDs per beat.
// Optional RD_ACTIVE_VERTEX_EARLY_EXIT_EN stops after an iteration that saw no activating update.
module rd_active_vertex_multi
  import rd_av_pkg::*;
#(
  parameter int V_ID_WIDTH = 20,
  parameter int ITERATION_WIDTH = 8,
  parameter int CORE_ID = 0,
  parameter int CORE_NUM_WIDTH = 4,
  parameter int BITMAP_LENGTH = 64,
  parameter int WORDS = 64,
  parameter int LANES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   vertex_num,
  input  logic [ITERATION_WIDTH-1:0]    iteration_num,
  input  logic [V_ID_WIDTH-1:0]         upd_v_id,
  input  logic                          upd_active,
  input  logic                          upd_valid,
  input  logic                          be_iter_end,
  input  logic [ITERATION_WIDTH-1:0]    be_iter_id,
  output logic [LANES*V_ID_WIDTH-1:0]   out_v_id,
  output logic [LANES-1:0]              out_lane_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          iter_end,
  output logic [ITERATION_WIDTH-1:0]    iteration_id,
  output logic                          iteration_done
);
  localparam int BIT_W = split_w(BITMAP_LENGTH);
  localparam int WORD_W = split_w(WORDS);
  state_t state, state_nx;
  logic [WORD_W-1:0] ptr;
  logic [BITMAP_LENGTH-1:0] work, rd, rd_live, cleared;
  logic [BITMAP_LENGTH-1:0] mem [2][WORDS];
  logic [LANES*BIT_W-1:0] lane_idx;
  logic [LANES-1:0] lane_valid;
  logic [31:0] upd_local, lane_id;
  logic cur, last_ptr, in_range_word, upd_en, ack, hs, word_exit, wb_en, adv, early;

  assign cur = iteration_id[0];
  assign last_ptr = ptr == WORD_W'(WORDS - 1);
  assign rd = mem[cur][ptr];
  // IDs rise monotonically with ptr, so a word whose first ID is out of range holds nothing emittable
  assign in_range_word = compose_id(32'(ptr), 32'd0, BITMAP_LENGTH, CORE_NUM_WIDTH, CORE_ID) < vertex_num;
  assign rd_live = in_range_word ? rd : '0;
  assign upd_en = upd_valid && (state == FETCH || state == SCAN || state == END);
  assign ack = state == END && be_iter_end && be_iter_id == iteration_id;
  assign hs = out_valid && out_ready;
  // lanes ascend, so a masked lane 0 means the rest of the word is out of range too
  assign word_exit = state == SCAN && (!out_valid || (hs && cleared == '0));
  assign wb_en = word_exit || (state == FETCH && !in_range_word);
  assign adv = state == INIT || (state == FETCH && rd_live == '0) || word_exit;
  assign upd_local = 32'(upd_v_id) >> CORE_NUM_WIDTH;

  multi_lane_bit_extract #(.BITMAP_LENGTH(BITMAP_LENGTH), .LANES(LANES)) u_extract (
    .word(work),
    .lane_idx(lane_idx),
    .lane_valid(lane_valid),
    .cleared(cleared)
  );

`ifdef RD_ACTIVE_VERTEX_EARLY_EXIT_EN
  logic seen, seen_now;
  assign seen_now = seen || (upd_en && upd_active);
  always_ff @(posedge clk) seen <= (rst || ack) ? 1'b0 : seen_now;
  assign early = !seen_now;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) state <= rst ? INIT : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      INIT:  if (last_ptr) state_nx = iteration_num == '0 ? DONE : FETCH;
      FETCH: state_nx = rd_live != '0 ? SCAN : last_ptr ? END : FETCH;
      SCAN:  if (word_exit) state_nx = last_ptr ? END : FETCH;
      END:   if (ack) state_nx = (iteration_id + ITERATION_WIDTH'(1) == iteration_num || early) ? DONE : FETCH;
      default: state_nx = DONE;
    endcase
  end

  always_comb begin
    lane_id = '0;
    out_v_id = '0;
    out_lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_id = compose_id(32'(ptr), 32'(lane_idx[l*BIT_W +: BIT_W]), BITMAP_LENGTH, CORE_NUM_WIDTH, CORE_ID);
      out_lane_valid[l] = state == SCAN && lane_valid[l] && lane_id < vertex_num;
      out_v_id[l*V_ID_WIDTH +: V_ID_WIDTH] = out_lane_valid[l] ? V_ID_WIDTH'(lane_id) : '0;
    end
    out_valid = |out_lane_valid;
    iter_end = state == END;
    iteration_done = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      work <= '0;
      iteration_id <= '0;
    end else begin
      if (adv) ptr <= last_ptr ? '0 : ptr + WORD_W'(1);
      if (state == FETCH) work <= rd_live;
      else if (hs) work <= cleared;
      if (ack) iteration_id <= iteration_id + ITERATION_WIDTH'(1);
    end
  end

  // write-back and updates always hit different banks, so both can land in one cycle
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[0][ptr] <= '1;
      mem[1][ptr] <= '0;
    end
    if (wb_en) mem[cur][ptr] <= '0;
    if (upd_en) mem[!cur][upd_local[BIT_W +: WORD_W]][upd_local[BIT_W-1:0]] <= upd_active;
  end
endmodule
